// File: rtl/mem_bus_pkg.sv
// Shared types for the two-port memory bus arbiter.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StIBus,
      StDBus,
      StResp
   } state_e;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_e;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

endpackage

// File: rtl/mem_bus_watchdog.sv
// Bus-cycle watchdog: counts wait cycles and flags the edge that would reach TIMEOUT.
module mem_bus_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] count_q, count_d;

   // Next count: clear wins over enable.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Expiry is the edge on which the count would step to TIMEOUT; a zero TIMEOUT never fires.
   assign expired = (TIMEOUT != 0) && (count_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and load/store ports onto one external bus with a watchdog abort.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ready,
   input  logic          d_req,
   input  logic          d_write,
   input  logic [1:0]    d_size,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          m_req,
   output logic          m_write,
   output logic [1:0]    m_size,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   output logic          m_wdata_oe,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ack_n,
   output logic          bus_err,
   output logic [AW-1:0] err_addr
);

   state_e        state_q, state_d;
   grant_e        last_grant_q, last_grant_d;
   logic          m_req_q, m_req_d, m_write_q, m_write_d;
   logic [1:0]    m_size_q, m_size_d;
   logic [AW-1:0] m_addr_q, m_addr_d, err_addr_q, err_addr_d;
   logic [DW-1:0] m_wdata_q, m_wdata_d;
   logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d, bus_rdata;
   logic          i_ready_q, i_ready_d, d_ready_q, d_ready_d, bus_err_q, bus_err_d;
   logic          in_bus, wd_clear, wd_enable, wd_expired;

   assign in_bus    = (state_q == StIBus) || (state_q == StDBus);
   assign wd_clear  = (state_q == StIdle);
   assign wd_enable = in_bus && m_ack_n;

   mem_bus_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (wd_clear),
      .enable (wd_enable),
      .expired(wd_expired)
   );

   // Arbitration, bus-cycle completion/abort and response pulses.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      m_req_d      = m_req_q;
      m_write_d    = m_write_q;
      m_size_d     = m_size_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      i_rdata_d    = i_rdata_q;
      d_rdata_d    = d_rdata_q;
      err_addr_d   = err_addr_q;
      i_ready_d    = 1'b0;
      d_ready_d    = 1'b0;
      bus_err_d    = 1'b0;
      bus_rdata    = m_ack_n ? '0 : m_rdata;
      unique case (state_q)
         StIdle: begin
            // Under contention the port not served last time wins.
            if (d_req && (!i_req || (last_grant_q == GRANT_I))) begin
               m_req_d      = 1'b1;
               m_write_d    = d_write;
               m_size_d     = d_size;
               m_addr_d     = d_addr;
               m_wdata_d    = d_wdata;
               last_grant_d = GRANT_D;
               state_d      = StDBus;
            end else if (i_req) begin
               m_req_d      = 1'b1;
               m_write_d    = 1'b0;
               m_size_d     = SZ_WORD;
               m_addr_d     = i_addr;
               m_wdata_d    = '0;
               last_grant_d = GRANT_I;
               state_d      = StIBus;
            end
         end
         StIBus, StDBus: begin
            if (!m_ack_n || wd_expired) begin
               if (state_q == StIBus) begin
                  i_rdata_d = bus_rdata;
                  i_ready_d = 1'b1;
               end else begin
                  d_rdata_d = bus_rdata;
                  d_ready_d = 1'b1;
               end
               if (m_ack_n) begin
                  bus_err_d  = 1'b1;
                  err_addr_d = m_addr_q;
               end
               m_req_d   = 1'b0;
               m_write_d = 1'b0;
               state_d   = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         last_grant_q <= GRANT_I;
         m_req_q      <= 1'b0;
         m_write_q    <= 1'b0;
         m_size_q     <= '0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
         err_addr_q   <= '0;
         i_ready_q    <= 1'b0;
         d_ready_q    <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         m_req_q      <= m_req_d;
         m_write_q    <= m_write_d;
         m_size_q     <= m_size_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         i_rdata_q    <= i_rdata_d;
         d_rdata_q    <= d_rdata_d;
         err_addr_q   <= err_addr_d;
         i_ready_q    <= i_ready_d;
         d_ready_q    <= d_ready_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign m_req      = m_req_q;
   assign m_write    = m_write_q;
   assign m_size     = m_size_q;
   assign m_addr     = m_addr_q;
   assign m_wdata    = m_wdata_q;
   assign m_wdata_oe = m_req_q & m_write_q;
   assign i_rdata    = i_rdata_q;
   assign d_rdata    = d_rdata_q;
   assign i_ready    = i_ready_q;
   assign d_ready    = d_ready_q;
   assign bus_err    = bus_err_q;
   assign err_addr   = err_addr_q;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port memory bus arbiter between the pipeline's instruction-fetch port and its load/store port, sharing a single external memory bus with an active-low acknowledge. When both ports request together, grants alternate between them. A watchdog timeout ends a stuck bus cycle with an error pulse. The block sits between the CPU core and the memory system, replacing the separate instruction and data buses. Each requester stalls by holding its request until its `ready` pulse.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 255, cycles a bus cycle may wait for ack before abort; 0 disables the watchdog
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_req`  in  1  fetch request; held with `i_addr` until `i_ready`
- `i_addr`  in  AW  fetch address
- `i_rdata`  out  DW  fetched word, valid while `i_ready`
- `i_ready`  out  1  one-cycle completion pulse, fetch port
- `d_req`  in  1  load/store request; held with its fields until `d_ready`
- `d_write`  in  1  1 = store, 0 = load
- `d_size`  in  2  access size: 00 word, 01 half, 10 byte
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `d_rdata`  out  DW  load data, valid while `d_ready`
- `d_ready`  out  1  one-cycle completion pulse, data port
- `m_req`  out  1  external bus cycle active
- `m_write`  out  1  external write strobe
- `m_size`  out  2  external size; 00 for fetches
- `m_addr`  out  AW  external address
- `m_wdata`  out  DW  external write data
- `m_wdata_oe`  out  1  tristate enable for the top-level data pin (`m_req & m_write`)
- `m_rdata`  in  DW  external read data
- `m_ack_n`  in  1  active-low bus acknowledge
- `bus_err`  out  1  one-cycle pulse on watchdog abort
- `err_addr`  out  AW  address of the last aborted cycle; held until the next abort

## Operation
- FSM states: IDLE, I_BUS, D_BUS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One port requesting: grant it.
  - Both requesting: grant the port not recorded in `last_grant`.
  - On grant: register all `m_*` fields from the granted port, update `last_grant`, enter the matching *_BUS state.
- `last_grant` resets to I, so the first contended grant goes to D.
- I_BUS / D_BUS:
  - `m_req` = 1; `m_*` fields are held stable.
  - Each cycle with `m_ack_n` = 1 increments the watchdog counter.
  - Edge sampling `m_ack_n` = 0: capture `m_rdata` into the granted port's rdata, drop `m_req`/`m_write`, go to RESP. Stores capture `m_rdata` too; it is don't-care.
  - Counter reaching `TIMEOUT` with ack still high: rdata := 0, `bus_err` pulses, `err_addr` := `m_addr`, go to RESP.
- RESP: granted port's `ready` = 1 for exactly this cycle; next state IDLE. This dead cycle keeps a held-over request from being granted twice.
- `m_ack_n` low in IDLE or RESP is ignored.
- Watchdog counter width is clog2(TIMEOUT+1). It clears on every grant.
- Reset values (all asynchronous): state IDLE, all `m_*` = 0, `i_ready` = `d_ready` = 0, `i_rdata` = `d_rdata` = 0, `bus_err` = 0, `err_addr` = 0, counter 0, `last_grant` = I.

## Timing
- Registered `m_*` outputs.
- Cycle numbering: request sampled at edge k; `m_req` high after edge k; ack sampled earliest at edge k+1; `ready` high in cycle k+1..k+2.
- Minimum latency from request to ready is 2 cycles.
- Minimum issue interval is 3 cycles per transfer.
- Requester may change or drop its request at the edge ending its `ready` cycle.
- Reset asserted mid-transfer:
  - `m_req`, `m_write`, `m_wdata_oe` drop immediately, without waiting for an edge.
  - Any pending ack is discarded.
  - No `ready` pulse is issued.
- Abort timing: the abort completes `TIMEOUT` cycles after `m_req` rises; `ready` and `bus_err` assert in the same cycle.

## Structure
- Shared package `mem_bus_pkg`: FSM state enum, grant enum (GRANT_I, GRANT_D), size encodings `SZ_WORD`/`SZ_HALF`/`SZ_BYTE`.
- One sub-module, `mem_bus_watchdog`: counter with clear, enable, and `expired` output, parameterised by `TIMEOUT`.

## Test plan
- Fetch only: `i_req` with `i_addr` = 0x0000_0040; `m_ack_n` low in the first bus cycle; `m_rdata` = 0x8C22_0004 → `m_req` high for 1 cycle, `m_size` = 00, `i_ready` 2 cycles after request with `i_rdata` = 0x8C22_0004; `d_ready` stays 0.
- Contention after reset: both request in the same cycle; D is a store of 0xDEAD_BEEF to 0x0000_1000, word size → D is granted first (`m_write` = 1, `m_wdata_oe` = 1, `m_wdata` = 0xDEAD_BEEF); fetch is granted at the next IDLE.
- Both ports request continuously with immediate acks → grant order D, I, D, I; one transfer every 3 cycles.
- `TIMEOUT` = 4, load from 0x0000_2000, ack never arrives → after 4 cycles in D_BUS: `d_ready` and `bus_err` pulse together, `d_rdata` = 0, `err_addr` = 0x0000_2000.
- `rst` asserted in the second cycle of D_BUS → `m_req`, `m_write`, `m_wdata_oe` go 0 with no clock edge; no `ready` pulse. After release, with both ports requesting, D is granted first.
- Stray `m_ack_n` low while in IDLE, then a fetch with ack after 3 wait cycles → stray ack ignored; `i_ready` arrives 5 cycles after the request.
